proc_status: RTL
================

# proc_status

Processor status register (P) for the 6502 core; sits directly downstream of `alu`, consuming `alu_Y`, `alu_carry_out` and `alu_overflow`. It commits flag updates selected by the control unit, handles the explicit set/clear instructions, PLP/RTI loads and interrupt entry, and produces the pushed status byte. It feeds the carry back to the ALU's `alu_carry_in` mux, and the delayed IRQ mask to interrupt logic.

## Interface
- No parameters. Flag bit positions and `flag_op` encodings are constants in `params.vh`.
- `clk`  in  1  core clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `alu_Y`  in  8  ALU result.
- `alu_carry_out`  in  1  ALU carry.
- `alu_overflow`  in  1  ALU overflow.
- `data_in`  in  8  data bus byte (PLP/RTI pull, BIT operand).
- `flag_op`  in  4  update selector (see Operation).
- `flag_en`  in  1  commit strobe; `flag_op` is ignored when low.
- `sync`  in  1  high for one cycle at each opcode fetch (instruction boundary).
- `push_brk`  in  1  B-bit value for `p_push` (1 = BRK/PHP, 0 = IRQ/NMI).
- `p_out`  out  8  registered P: {N,V,1,0,D,I,Z,C}.
- `p_push`  out  8  combinational: `p_out` with bit4 = `push_brk`.
- `carry_flag`  out  1  C, to ALU carry-in mux.
- `decimal_flag`  out  1  D.
- `irq_masked`  out  1  effective IRQ mask seen by interrupt logic.

## Operation
- Stored state: N, V, D, I, Z, C, plus `irq_mask_q`. Bit5 always reads 1; bit4 always reads 0 in `p_out`.
- `flag_op` encodings, all committed only when `flag_en`=1:
  - NOP=0: no change.
  - NZ=1: N=`alu_Y[7]`, Z=(`alu_Y`==0).
  - NZC=2: NZ plus C=`alu_carry_out`. Used for shifts and compares.
  - NZCV=3: NZC plus V=`alu_overflow`.
  - BIT=4: N=`data_in[7]`, V=`data_in[6]`, Z=(`alu_Y`==0).
  - SEC=5 / CLC=6, SEI=7 / CLI=8, SED=9 / CLD=10, CLV=11: set or clear the single named flag.
  - LOAD=12: N,V,D,I,Z,C from `data_in` bits 7,6,3,2,1,0; bits 5 and 4 are discarded.
  - INT=13: I=1, and `irq_mask_q`=1 in the same edge.
  - 14–15: reserved, behave as NOP.
- IRQ-mask latency: `irq_mask_q` loads the I value in effect at the edge where `sync`=1. A SEI, CLI or LOAD therefore affects `irq_masked` only from the next instruction boundary. The exception is INT, which masks immediately.
- `irq_masked` = `irq_mask_q`.
- Simultaneous `sync` and a commit on the same edge: `irq_mask_q` samples the pre-commit I, except for INT, which forces 1.
- Unaffected flags hold their value in every op.

## Timing
- Reset (async assert, sync release implicit via `clk`): N=V=D=Z=C=0, I=1, `irq_mask_q`=1.
  - `p_out`=8'h24, `p_push`=8'h24 or 8'h34 per `push_brk`, `carry_flag`=0, `decimal_flag`=0, `irq_masked`=1.
- Commit latency: inputs are sampled at the edge with `flag_en`=1, and the new P appears on `p_out` immediately after that edge. There is no pipelining.
- Back-to-back commits on consecutive cycles are legal. Each one sees the P produced by the previous commit.
- Reset asserted mid-instruction discards any pending update. The first post-reset commit is handled normally.
- `p_push` and `carry_flag` are combinational from state and `push_brk` only; they have no path from the ALU inputs.

## Structure
- `params.vh` gains: flag bit indices (FLAG_N=7, FLAG_V=6, FLAG_B=4, FLAG_D=3, FLAG_I=2, FLAG_Z=1, FLAG_C=0), the `flag_op` localparams above, and the reset value P_RESET=8'h24.
- Single module, no sub-modules. Next-state logic is one combinational case on `flag_op`, feeding one async-reset register block.

## Test plan
- Reset: assert `resetn`=0 mid-run → `p_out`=8'h24 and `irq_masked`=1 immediately, without waiting for a clock.
- NZCV: `alu_Y`=8'h00, carry=1, overflow=1, op=3, `flag_en`=1 → next cycle `p_out`=8'h67. Then `alu_Y`=8'h80, carry=0, overflow=0 → `p_out`=8'hA4.
- BIT: from 8'h24, `data_in`=8'hC0, `alu_Y`=8'h00, op=4 → `p_out`=8'hE6. With `flag_en`=0 and the same inputs → no change.
- LOAD/push: `data_in`=8'hFF, op=12 → `p_out`=8'hEF. `push_brk`=1 → `p_push`=8'hFF; `push_brk`=0 → `p_push`=8'hEF.
- CLI latency: I=1, commit CLI at cycle t, `sync` first at t+3 → `irq_masked` stays 1 through t+3 and is 0 from t+4. SEI behaves symmetrically. A commit coinciding with `sync` leaves the old mask in place.
- INT: while `irq_masked`=0, commit INT → I=1 and `irq_masked`=1 on the same edge, with no `sync` required. A reserved op (14) leaves `p_out` unchanged.

Source files
------------

// File: rtl/proc_status_pkg.sv
// proc_status_pkg: flag bit positions, flag_op encodings and the reset value of P.
package proc_status_pkg;
    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_B = 4;
    localparam int FLAG_D = 3;
    localparam int FLAG_I = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;
    localparam logic [7:0] P_RESET = 8'h24;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_NZ   = 4'd1,
        OP_NZC  = 4'd2,
        OP_NZCV = 4'd3,
        OP_BIT  = 4'd4,
        OP_SEC  = 4'd5,
        OP_CLC  = 4'd6,
        OP_SEI  = 4'd7,
        OP_CLI  = 4'd8,
        OP_SED  = 4'd9,
        OP_CLD  = 4'd10,
        OP_CLV  = 4'd11,
        OP_LOAD = 4'd12,
        OP_INT  = 4'd13
    } flag_op_e;

    function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] y);
        set_nz = p;
        set_nz[FLAG_N] = y[7];
        set_nz[FLAG_Z] = (y == 8'h00);
    endfunction
endpackage

// File: rtl/proc_status_if.sv
// proc_status_if: ALU/control inputs and status outputs of the P register.
interface proc_status_if;
    logic [7:0] alu_Y;
    logic       alu_carry_out;
    logic       alu_overflow;
    logic [7:0] data_in;
    logic [3:0] flag_op;
    logic       flag_en;
    logic       sync;
    logic       push_brk;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry_flag;
    logic       decimal_flag;
    logic       irq_masked;

    modport master (
        output alu_Y, alu_carry_out, alu_overflow, data_in, flag_op, flag_en, sync, push_brk,
        input  p_out, p_push, carry_flag, decimal_flag, irq_masked
    );
    modport slave (
        input  alu_Y, alu_carry_out, alu_overflow, data_in, flag_op, flag_en, sync, push_brk,
        output p_out, p_push, carry_flag, decimal_flag, irq_masked
    );
endinterface

// File: rtl/proc_status.sv
// proc_status: 6502 P register with flag commits, pushed-status byte and delayed IRQ mask.
module proc_status
    import proc_status_pkg::*;
(
    input logic          clk,
    input logic          resetn,
    proc_status_if.slave bus
);
    logic [7:0] p_q, p_d;
    logic       mask_q, mask_d;

    always_comb begin
        p_d = p_q;
        // mask follows the pre-commit I at instruction boundaries; INT overrides below
        mask_d = bus.sync ? p_q[FLAG_I] : mask_q;
        if (bus.flag_en) begin
            case (bus.flag_op)
                OP_NZ:   p_d = set_nz(p_q, bus.alu_Y);
                OP_NZC:  begin
                    p_d = set_nz(p_q, bus.alu_Y);
                    p_d[FLAG_C] = bus.alu_carry_out;
                end
                OP_NZCV: begin
                    p_d = set_nz(p_q, bus.alu_Y);
                    p_d[FLAG_C] = bus.alu_carry_out;
                    p_d[FLAG_V] = bus.alu_overflow;
                end
                OP_BIT:  begin
                    p_d = set_nz(p_q, bus.alu_Y);
                    p_d[FLAG_N] = bus.data_in[7];
                    p_d[FLAG_V] = bus.data_in[6];
                end
                OP_SEC:  p_d[FLAG_C] = 1'b1;
                OP_CLC:  p_d[FLAG_C] = 1'b0;
                OP_SEI:  p_d[FLAG_I] = 1'b1;
                OP_CLI:  p_d[FLAG_I] = 1'b0;
                OP_SED:  p_d[FLAG_D] = 1'b1;
                OP_CLD:  p_d[FLAG_D] = 1'b0;
                OP_CLV:  p_d[FLAG_V] = 1'b0;
                OP_LOAD: p_d = bus.data_in;
                OP_INT:  begin
                    p_d[FLAG_I] = 1'b1;
                    mask_d = 1'b1;
                end
                default: ;
            endcase
        end
        p_d[5] = 1'b1;
        p_d[FLAG_B] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_q <= P_RESET;
            mask_q <= 1'b1;
        end else begin
            p_q <= p_d;
            mask_q <= mask_d;
        end
    end

    assign bus.p_out = p_q;
    assign bus.p_push = {p_q[7:5], bus.push_brk, p_q[3:0]};
    assign bus.carry_flag = p_q[FLAG_C];
    assign bus.decimal_flag = p_q[FLAG_D];
    assign bus.irq_masked = mask_q;
endmodule
